// File: rtl/fifo_frame_writer_if.sv
// Ingress stream, FIFO write port and statistics of the frame writer.
// The writer takes the master view; the environment (upstream + FIFO) takes the slave view.
interface fifo_frame_writer_if #(
  parameter int DATA_WIDTH = 360,
  parameter int CNT_BITS   = 11,
  parameter int CNT_WIDTH  = 16
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  s_ready;

  logic                  wr_en;
  logic [DATA_WIDTH:0]   wr_data;
  logic                  wr_full;
  logic [CNT_BITS-1:0]   wr_cnt;

  logic [CNT_WIDTH-1:0]  frame_cnt;
  logic [CNT_WIDTH-1:0]  drop_cnt;
  logic [CNT_WIDTH-1:0]  trunc_cnt;

  modport master (
    input  s_valid, s_data, s_last, wr_full, wr_cnt,
    output s_ready, wr_en, wr_data, frame_cnt, drop_cnt, trunc_cnt
  );

  modport slave (
    output s_valid, s_data, s_last, wr_full, wr_cnt,
    input  s_ready, wr_en, wr_data, frame_cnt, drop_cnt, trunc_cnt
  );
endinterface

// File: rtl/fifo_frame_writer.sv
// Frame-atomic FIFO writer: admits a whole frame only if the FIFO has room for a
// maximum-size frame, truncates oversize frames, and tags each word with a last flag.
module fifo_frame_writer #(
  parameter int DATA_WIDTH      = 360,
  parameter int FIFO_DEPTH      = 1024,
  parameter int C_REAL_DEPTH    = 2**$clog2(FIFO_DEPTH),
  parameter int C_DEPTH_P1_BITS = $clog2(C_REAL_DEPTH+1),
  parameter int MAX_FRAME_WORDS = 64,
  parameter int GUARD_WORDS     = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_frame_writer_if.master  bus
);
  localparam int BC_W   = $clog2(MAX_FRAME_WORDS+1);
  localparam int FREE_W = C_DEPTH_P1_BITS + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PASS = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]            state, state_n;
  logic [BC_W-1:0]       beat_cnt, beat_cnt_n;
  logic [FREE_W-1:0]     free;
  logic                  admit, ready, accept;
  logic                  wr_n, flag_n;
  logic                  inc_frame, inc_drop, inc_trunc;
  logic                  wr_en_q;
  logic [DATA_WIDTH:0]   wr_data_q;
  logic [CNT_WIDTH-1:0]  frame_cnt, drop_cnt, trunc_cnt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic en);
    return (en && c != '1) ? c + 1'b1 : c;
  endfunction

  // One extra bit keeps an out-of-range occupancy negative instead of wrapping to "lots free".
  assign free  = FREE_W'(C_REAL_DEPTH) - {1'b0, bus.wr_cnt};
  assign admit = !free[FREE_W-1] && (free >= FREE_W'(MAX_FRAME_WORDS + GUARD_WORDS));

  assign ready  = rst || (state != PASS) || !bus.wr_full;
  assign accept = bus.s_valid && ready && !rst;

  always_comb begin
    state_n    = state;
    beat_cnt_n = beat_cnt;
    wr_n       = 1'b0;
    flag_n     = bus.s_last;
    inc_frame  = 1'b0;
    inc_drop   = 1'b0;
    inc_trunc  = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (admit) begin
            wr_n       = 1'b1;
            inc_frame  = 1'b1;
            beat_cnt_n = BC_W'(1);
            if (!bus.s_last) begin
              if (MAX_FRAME_WORDS == 1) begin
                flag_n    = 1'b1;
                inc_trunc = 1'b1;
                state_n   = DROP;
              end else begin
                state_n = PASS;
              end
            end
          end else begin
            inc_drop = 1'b1;
            if (!bus.s_last) state_n = DROP;
          end
        end
        PASS: begin
          wr_n       = 1'b1;
          beat_cnt_n = beat_cnt + 1'b1;
          if (bus.s_last) begin
            state_n = IDLE;
          end else if (beat_cnt_n == BC_W'(MAX_FRAME_WORDS)) begin
            // Close the frame early so the reader still sees a delimiter.
            flag_n    = 1'b1;
            inc_trunc = 1'b1;
            state_n   = DROP;
          end
        end
        DROP: begin
          if (bus.s_last) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
      trunc_cnt <= '0;
    end else begin
      state     <= state_n;
      beat_cnt  <= beat_cnt_n;
      wr_en_q   <= wr_n;
      if (wr_n) wr_data_q <= {flag_n, bus.s_data};
      frame_cnt <= sat_inc(frame_cnt, inc_frame);
      drop_cnt  <= sat_inc(drop_cnt,  inc_drop);
      trunc_cnt <= sat_inc(trunc_cnt, inc_trunc);
    end
  end

  assign bus.s_ready   = ready;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.frame_cnt = frame_cnt;
  assign bus.drop_cnt  = drop_cnt;
  assign bus.trunc_cnt = trunc_cnt;
endmodule

// File: tb/tb_fifo_frame_writer.sv
// Directed bench for fifo_frame_writer: admission, drop, truncation, backpressure,
// reset mid-frame and statistics saturation.
module tb_fifo_frame_writer;
  localparam int DW = 16;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [DW:0] wq[$];

  fifo_frame_writer_if #(.DATA_WIDTH(DW), .CNT_BITS(11), .CNT_WIDTH(16)) bus ();

  fifo_frame_writer #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(1024), .MAX_FRAME_WORDS(64),
    .GUARD_WORDS(4), .CNT_WIDTH(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (!rst && bus.wr_en) wq.push_back(bus.wr_data);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat for one cycle; returns at the following negedge.
  task automatic beat(input logic v, input logic [DW-1:0] d, input logic l);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.s_last  = l;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = 16'hDEAD; bus.s_last = 1'b1;
    bus.wr_full = 1'b0; bus.wr_cnt = '0;
    #1;
    chk("ready_in_reset", 64'(bus.s_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    beat(1'b0, '0, 1'b0);
    chk("rst_wr_en",   64'(bus.wr_en),     64'd0);
    chk("rst_wr_data", 64'(bus.wr_data),   64'd0);
    chk("rst_frame",   64'(bus.frame_cnt), 64'd0);
    chk("rst_drop",    64'(bus.drop_cnt),  64'd0);
    chk("rst_trunc",   64'(bus.trunc_cnt), 64'd0);

    // Normal 5-beat frame, one-cycle latency per beat.
    for (int i = 1; i <= 5; i++) begin
      beat(1'b1, DW'(i), i == 5);
      chk("t1_wr_en",   64'(bus.wr_en),   64'd1);
      chk("t1_wr_data", 64'(bus.wr_data), 64'({i == 5, 16'(i)}));
    end
    beat(1'b0, '0, 1'b0);
    chk("t1_idle_wr_en", 64'(bus.wr_en),     64'd0);
    chk("t1_frame",      64'(bus.frame_cnt), 64'd1);

    // Drop at admission: free 67 < 68.
    bus.wr_cnt = 11'd957;
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, DW'(16'h50 + i), i == 2);
      chk("t2_drop_wr_en", 64'(bus.wr_en),   64'd0);
      chk("t2_ready",      64'(bus.s_ready), 64'd1);
    end
    chk("t2_drop_cnt",  64'(bus.drop_cnt),  64'd1);
    chk("t2_frame_cnt", 64'(bus.frame_cnt), 64'd1);
    bus.wr_cnt = 11'd956;
    beat(1'b1, 16'h60, 1'b0);
    chk("t2_admit_wr_en", 64'(bus.wr_en),   64'd1);
    chk("t2_admit_data",  64'(bus.wr_data), 64'({1'b0, 16'h60}));
    bus.wr_cnt = 11'd0;
    beat(1'b1, 16'h61, 1'b1);
    chk("t2_admit_last",  64'(bus.wr_data), 64'({1'b1, 16'h61}));
    chk("t2_frame_cnt2",  64'(bus.frame_cnt), 64'd2);
    beat(1'b0, '0, 1'b0);

    // Oversize frame truncated at 64 words.
    wq.delete();
    for (int i = 0; i < 70; i++) beat(1'b1, DW'(100 + i), i == 69);
    beat(1'b0, '0, 1'b0);
    beat(1'b0, '0, 1'b0);
    chk("t3_nwrites", 64'(wq.size()), 64'd64);
    if (wq.size() == 64) begin
      chk("t3_first", 64'(wq[0]),  64'({1'b0, 16'd100}));
      chk("t3_w62",   64'(wq[62]), 64'({1'b0, 16'd162}));
      chk("t3_w63",   64'(wq[63]), 64'({1'b1, 16'd163}));
    end
    chk("t3_trunc", 64'(bus.trunc_cnt), 64'd1);
    chk("t3_frame", 64'(bus.frame_cnt), 64'd3);

    // Exactly 64 beats: natural last, no truncation.
    wq.delete();
    for (int i = 0; i < 64; i++) beat(1'b1, DW'(300 + i), i == 63);
    beat(1'b0, '0, 1'b0);
    beat(1'b0, '0, 1'b0);
    chk("t3b_nwrites", 64'(wq.size()), 64'd64);
    if (wq.size() == 64) chk("t3b_w63", 64'(wq[63]), 64'({1'b1, 16'd363}));
    chk("t3b_trunc", 64'(bus.trunc_cnt), 64'd1);
    chk("t3b_frame", 64'(bus.frame_cnt), 64'd4);

    // Backpressure for 3 cycles mid-frame.
    wq.delete();
    for (int i = 0; i < 3; i++) beat(1'b1, DW'(200 + i), 1'b0);
    bus.wr_full = 1'b1;
    bus.s_data  = 16'd203;
    bus.s_last  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_ready_full", 64'(bus.s_ready), 64'd0);
      @(negedge clk);
      if (c > 0) chk("t4_no_wr_full", 64'(bus.wr_en), 64'd0);
    end
    bus.wr_full = 1'b0;
    #1;
    chk("t4_ready_back", 64'(bus.s_ready), 64'd1);
    @(negedge clk);
    for (int i = 4; i < 8; i++) beat(1'b1, DW'(200 + i), i == 7);
    beat(1'b0, '0, 1'b0);
    beat(1'b0, '0, 1'b0);
    chk("t4_nwrites", 64'(wq.size()), 64'd8);
    if (wq.size() == 8)
      for (int k = 0; k < 8; k++) chk("t4_word", 64'(wq[k]), 64'({k == 7, 16'(200 + k)}));
    chk("t4_frame", 64'(bus.frame_cnt), 64'd5);

    // Back-to-back single-beat frames.
    beat(1'b1, 16'hA, 1'b1);
    chk("t4_A", 64'({bus.wr_en, bus.wr_data}), 64'({1'b1, 1'b1, 16'hA}));
    beat(1'b1, 16'hB, 1'b1);
    chk("t4_B", 64'({bus.wr_en, bus.wr_data}), 64'({1'b1, 1'b1, 16'hB}));
    beat(1'b1, 16'hC, 1'b1);
    chk("t4_C", 64'({bus.wr_en, bus.wr_data}), 64'({1'b1, 1'b1, 16'hC}));
    beat(1'b0, '0, 1'b0);
    chk("t4_abc_frame", 64'(bus.frame_cnt), 64'd8);

    // Reset after beat 2 of 5.
    beat(1'b1, 16'h31, 1'b0);
    beat(1'b1, 16'h32, 1'b0);
    chk("t5_pre_wr_en", 64'(bus.wr_en), 64'd1);
    rst = 1'b1;
    beat(1'b1, 16'h33, 1'b0);
    rst = 1'b0;
    chk("t5_wr_en",  64'(bus.wr_en),     64'd0);
    chk("t5_frame",  64'(bus.frame_cnt), 64'd0);
    chk("t5_drop",   64'(bus.drop_cnt),  64'd0);
    chk("t5_trunc",  64'(bus.trunc_cnt), 64'd0);
    beat(1'b1, 16'h34, 1'b0);
    chk("t5_new_wr",    64'({bus.wr_en, bus.wr_data}), 64'({1'b1, 1'b0, 16'h34}));
    chk("t5_new_frame", 64'(bus.frame_cnt), 64'd1);
    beat(1'b1, 16'h35, 1'b1);
    beat(1'b0, '0, 1'b0);

    // Drop counter saturation via consecutive single-beat drops.
    bus.wr_cnt  = 11'd1000;
    bus.s_valid = 1'b1;
    bus.s_last  = 1'b1;
    repeat (65535) @(negedge clk);
    chk("t6_drop_max", 64'(bus.drop_cnt), 64'hFFFF);
    @(negedge clk);
    @(negedge clk);
    chk("t6_drop_sat", 64'(bus.drop_cnt),  64'hFFFF);
    chk("t6_frame",    64'(bus.frame_cnt), 64'd1);
    bus.s_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
